// File: rtl/acq_trigger_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// acq_pkg
// Shared types and constants for the acquisition trigger sequencer.
//   acq_state_t  : capture sequencer states
//   EDGE_RISING  : trig_edge encoding for a rising crossing
//   EDGE_FALLING : trig_edge encoding for a falling crossing
// -----------------------------------------------------------------------------
package acq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        ARMED = 3'd2,
        POST  = 3'd3,
        DONE  = 3'd4
    } acq_state_t;

    localparam logic EDGE_RISING  = 1'b0;
    localparam logic EDGE_FALLING = 1'b1;

endpackage

// File: rtl/acq_trigger_sequencer_level_cross_detect.sv
// -----------------------------------------------------------------------------
// level_cross_detect
// Tracks the previous valid sample and flags a level crossing between it and
// the current valid sample.
//   clk, rst       : clock, synchronous active-high reset
//   clear          : forget the previous sample (new capture starting)
//   sample_en      : previous-sample register may update this cycle
//   in_data_valid  : sample strobe
//   in_data        : current sample
//   level          : crossing threshold
//   trig_edge      : EDGE_RISING / EDGE_FALLING
//   hit            : current valid sample completes a crossing
// -----------------------------------------------------------------------------
module level_cross_detect
    import acq_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter bit TWOS_COMPLEMENT = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  sample_en,
    input  logic                  in_data_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [DATA_WIDTH-1:0] level,
    input  logic                  trig_edge,
    output logic                  hit
);

    logic [DATA_WIDTH-1:0] prev;
    logic                  prev_valid;
    logic                  prev_lt;
    logic                  prev_gt;
    logic                  cur_ge;
    logic                  cur_le;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, whatever the block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev       <= '0;
            prev_valid <= 1'b0;
        end else if (clear) begin
            prev_valid <= 1'b0;
        end else if (sample_en && in_data_valid) begin
            prev       <= in_data;
            prev_valid <= 1'b1;
        end
    end

    // NOTE: every combinational output is given a default before any branch,
    // so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        prev_lt = 1'b0;
        prev_gt = 1'b0;
        cur_ge  = 1'b0;
        cur_le  = 1'b0;
        if (TWOS_COMPLEMENT) begin
            prev_lt = $signed(prev)    <  $signed(level);
            prev_gt = $signed(prev)    >  $signed(level);
            cur_ge  = $signed(in_data) >= $signed(level);
            cur_le  = $signed(in_data) <= $signed(level);
        end else begin
            prev_lt = prev    <  level;
            prev_gt = prev    >  level;
            cur_ge  = in_data >= level;
            cur_le  = in_data <= level;
        end
    end

    // A crossing needs two samples: the first one after a clear only primes prev.
    assign hit = in_data_valid && prev_valid &&
                 ((trig_edge == EDGE_FALLING) ? (prev_gt && cur_le)
                                              : (prev_lt && cur_ge));

endmodule

// File: rtl/acq_trigger_sequencer.sv
// -----------------------------------------------------------------------------
// acq_trigger_sequencer
// Oscilloscope-style capture controller between the ADC stream and the DMA
// writer: pre-trigger fill, armed wait, post-trigger fill, completion.
//   clk, rst               : clock, synchronous active-high reset
//   start / abort          : one-cycle arm / cancel requests from the HPS
//   auto_rearm             : restart the pre-fill straight after DONE
//   pre_samples            : valid samples stored before arming
//   post_samples           : valid samples stored after the trigger sample
//   trigger_level          : crossing threshold
//   trig_edge              : 0 = rising, 1 = falling
//   in_data_valid, in_data : sample stream
//   in_dma_master_address  : DMA address of the current sample
//   capture_en             : DMA write enable for the current sample
//   busy / armed           : state != IDLE / state == ARMED
//   done / aborted         : one-cycle completion / cancel pulses
//   trig_address           : DMA address of the trigger sample
// -----------------------------------------------------------------------------
module acq_trigger_sequencer
    import acq_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int ADDR_WIDTH      = 32,
    parameter int CNT_WIDTH       = 16,
    parameter bit TWOS_COMPLEMENT = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  auto_rearm,
    input  logic [CNT_WIDTH-1:0]  pre_samples,
    input  logic [CNT_WIDTH-1:0]  post_samples,
    input  logic [DATA_WIDTH-1:0] trigger_level,
    input  logic                  trig_edge,
    input  logic                  in_data_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [ADDR_WIDTH-1:0] in_dma_master_address,
    output logic                  capture_en,
    output logic                  busy,
    output logic                  armed,
    output logic                  done,
    output logic                  aborted,
    output logic [ADDR_WIDTH-1:0] trig_address
);

    acq_state_t            state;
    acq_state_t            state_next;

    logic [CNT_WIDTH-1:0]  cnt;
    logic [CNT_WIDTH-1:0]  cnt_inc;
    logic [CNT_WIDTH-1:0]  sh_pre;
    logic [CNT_WIDTH-1:0]  sh_post;
    logic [DATA_WIDTH-1:0] sh_level;
    logic                  sh_edge;

    logic                  sample_en;
    logic                  hit;
    logic                  pre_reached;
    logic                  post_reached;

    // Control strobes from the next-state logic to the datapath registers.
    logic                  load_cfg;
    logic                  cnt_clr;
    logic                  cnt_step;
    logic                  trig_load;
    logic                  abort_set;

    // Saturating increment: the counter parks at all-ones instead of wrapping.
    assign cnt_inc = (cnt == {CNT_WIDTH{1'b1}}) ? cnt : cnt + CNT_WIDTH'(1);

    // A window closes on the sample that brings the count to its target; a
    // zero-length window is already satisfied on entry and lasts one cycle.
    assign pre_reached  = (cnt == sh_pre)  || (in_data_valid && (cnt_inc == sh_pre));
    assign post_reached = (cnt == sh_post) || (in_data_valid && (cnt_inc == sh_post));

    assign sample_en  = (state == PRE) || (state == ARMED) || (state == POST);
    assign capture_en = in_data_valid && sample_en;
    assign busy       = (state != IDLE);
    assign armed      = (state == ARMED);
    assign done       = (state == DONE);
    // aborted is a register driven directly from the datapath block below.

    level_cross_detect #(
        .DATA_WIDTH      (DATA_WIDTH),
        .TWOS_COMPLEMENT (TWOS_COMPLEMENT)
    ) u_detect (
        .clk           (clk),
        .rst           (rst),
        .clear         (load_cfg),
        .sample_en     (sample_en),
        .in_data_valid (in_data_valid),
        .in_data       (in_data),
        .level         (sh_level),
        .trig_edge     (sh_edge),
        .hit           (hit)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_cfg   = 1'b0;
        cnt_clr    = 1'b0;
        cnt_step   = 1'b0;
        trig_load  = 1'b0;
        abort_set  = 1'b0;
        unique case (state)
            IDLE: begin
                // abort wins over a simultaneous start and produces no pulse
                if (start && !abort) begin
                    load_cfg   = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = PRE;
                end
            end
            PRE: begin
                if (abort) begin
                    abort_set  = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_step = in_data_valid;
                    if (pre_reached) state_next = ARMED;
                end
            end
            ARMED: begin
                if (abort) begin
                    abort_set  = 1'b1;
                    state_next = IDLE;
                end else if (hit) begin
                    trig_load  = 1'b1;
                    cnt_clr    = 1'b1;   // the trigger sample is not a post sample
                    state_next = POST;
                end
            end
            POST: begin
                if (abort) begin
                    abort_set  = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_step = in_data_valid;
                    if (post_reached) state_next = DONE;
                end
            end
            DONE: begin
                // done is already showing this cycle; abort only cancels the rearm
                abort_set = abort;
                if (auto_rearm && !abort) begin
                    load_cfg   = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = PRE;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            sh_pre       <= '0;
            sh_post      <= '0;
            sh_level     <= '0;
            sh_edge      <= EDGE_RISING;
            trig_address <= '0;
            aborted      <= 1'b0;
        end else begin
            aborted <= abort_set;
            if (load_cfg) begin
                sh_pre   <= pre_samples;
                sh_post  <= post_samples;
                sh_level <= trigger_level;
                sh_edge  <= trig_edge;
            end
            if (cnt_clr)       cnt <= '0;
            else if (cnt_step) cnt <= cnt_inc;
            if (trig_load) trig_address <= in_dma_master_address;
        end
    end

endmodule

// File: tb/tb_acq_trigger_sequencer.sv
// -----------------------------------------------------------------------------
// tb_acq_trigger_sequencer
// Directed bench for acq_trigger_sequencer. Two instances share all inputs:
// dut_u uses unsigned compares, dut_s signed compares. Inputs change 1 ns
// after the rising edge; outputs are checked there or after a further 1 ns.
// -----------------------------------------------------------------------------
module tb_acq_trigger_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        auto_rearm;
    logic [15:0] pre_samples;
    logic [15:0] post_samples;
    logic [15:0] trigger_level;
    logic        trig_edge;
    logic        in_data_valid;
    logic [15:0] in_data;
    logic [31:0] in_dma_master_address;

    logic        u_capture_en, u_busy, u_armed, u_done, u_aborted;
    logic [31:0] u_trig_address;
    logic        s_capture_en, s_busy, s_armed, s_done, s_aborted;
    logic [31:0] s_trig_address;

    int errors = 0;
    int checks = 0;
    int n_cap  = 0;
    int n_done = 0;
    int n_abort = 0;
    int c0, d0, a0;

    always #5 clk = ~clk;

    acq_trigger_sequencer #(.TWOS_COMPLEMENT(1'b0)) dut_u (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .auto_rearm(auto_rearm),
        .pre_samples(pre_samples), .post_samples(post_samples),
        .trigger_level(trigger_level), .trig_edge(trig_edge),
        .in_data_valid(in_data_valid), .in_data(in_data),
        .in_dma_master_address(in_dma_master_address),
        .capture_en(u_capture_en), .busy(u_busy), .armed(u_armed), .done(u_done),
        .aborted(u_aborted), .trig_address(u_trig_address)
    );

    acq_trigger_sequencer #(.TWOS_COMPLEMENT(1'b1)) dut_s (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .auto_rearm(auto_rearm),
        .pre_samples(pre_samples), .post_samples(post_samples),
        .trigger_level(trigger_level), .trig_edge(trig_edge),
        .in_data_valid(in_data_valid), .in_data(in_data),
        .in_dma_master_address(in_dma_master_address),
        .capture_en(s_capture_en), .busy(s_busy), .armed(s_armed), .done(s_done),
        .aborted(s_aborted), .trig_address(s_trig_address)
    );

    // Event counters for dut_u, sampled mid-cycle.
    always @(negedge clk) begin
        if (u_capture_en) n_cap++;
        if (u_done)       n_done++;
        if (u_aborted)    n_abort++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one valid sample for one cycle.
    task automatic sample(input logic [15:0] d, input logic [31:0] a);
        in_data_valid         = 1'b1;
        in_data               = d;
        in_dma_master_address = a;
        tick();
        in_data_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; auto_rearm = 1'b0;
        pre_samples = '0; post_samples = '0; trigger_level = '0; trig_edge = 1'b0;
        in_data_valid = 1'b0; in_data = '0; in_dma_master_address = '0;
        repeat (3) tick();

        // ---------------- reset state ----------------
        in_data_valid = 1'b1;
        #1;
        check("rst_busy",       u_busy,         1'b0);
        check("rst_armed",      u_armed,        1'b0);
        check("rst_done",       u_done,         1'b0);
        check("rst_aborted",    u_aborted,      1'b0);
        check("rst_capture_en", u_capture_en,   1'b0);
        check("rst_trig_addr",  u_trig_address, 32'h0);
        in_data_valid = 1'b0;
        rst = 1'b0;
        tick();

        // ---------------- single rising capture on a ramp ----------------
        pre_samples = 16'd4; post_samples = 16'd3; trigger_level = 16'd1000; trig_edge = 1'b0;
        c0 = n_cap; d0 = n_done; a0 = n_abort;
        pulse_start();
        check("ramp_busy_after_start", u_busy, 1'b1);
        for (int k = 0; k < 2046 && n_done == d0; k++) begin
            sample(16'(k), 32'(32'h1000_0000 + 4 * k));
            if (k == 500) begin
                // start while armed, with new live settings: must change nothing
                pre_samples = 16'd1; trigger_level = 16'd300;
                pulse_start();
                check("ramp_start_ignored", u_armed, 1'b1);
                repeat (4) tick();
            end else begin
                repeat (5) tick();
            end
        end
        check("ramp_done_count", 64'(n_done - d0), 64'd1);
        check("ramp_capture_count", 64'(n_cap - c0), 64'd1004);
        check("ramp_trig_addr", u_trig_address, 32'h1000_0000 + 32'd4000);
        check("ramp_idle_after", u_busy, 1'b0);
        check("ramp_no_abort", 64'(n_abort - a0), 64'd0);

        // ---------------- falling edge, signed vs unsigned ----------------
        pre_samples = 16'd1; post_samples = 16'd0; trigger_level = 16'hFFFB; trig_edge = 1'b1;
        pulse_start();
        sample(16'd10,   32'h2000_0000); tick();
        sample(16'd0,    32'h2000_0010); tick();
        sample(16'hFFFC, 32'h2000_0020); tick();
        check("fall_no_early_trig_s", s_armed, 1'b1);
        sample(16'd10,   32'h2000_0030);
        check("fall_misread_no_trig_s", s_armed, 1'b1);
        check("fall_misread_trig_u", u_armed, 1'b0);
        check("fall_misread_addr_u", u_trig_address, 32'h2000_0030);
        tick();
        sample(16'hFFFC, 32'h2000_0040); tick();
        check("fall_m4_no_trig_s", s_armed, 1'b1);
        sample(16'hFFFA, 32'h2000_0050);
        check("fall_trig_s", s_armed, 1'b0);
        check("fall_trig_addr_s", s_trig_address, 32'h2000_0050);
        tick();
        check("fall_done_s", s_done, 1'b1);
        tick();
        check("fall_idle_s", s_busy, 1'b0);

        // ---------------- zero-length windows ----------------
        pre_samples = 16'd0; post_samples = 16'd0; trigger_level = 16'd100; trig_edge = 1'b0;
        pulse_start();
        check("zero_pre_state", {u_busy, u_armed}, 2'b10);
        tick();
        check("zero_armed_after_1", u_armed, 1'b1);
        sample(16'd50, 32'h3000_0000);
        check("zero_first_primes", u_armed, 1'b1);
        sample(16'd150, 32'h3000_0004);
        check("zero_post_cycle", {u_busy, u_armed, u_done}, 3'b100);
        tick();
        check("zero_done_plus2", u_done, 1'b1);
        tick();
        check("zero_done_single", {u_busy, u_done}, 2'b00);
        check("zero_trig_addr", u_trig_address, 32'h3000_0004);

        // ---------------- abort in ARMED ----------------
        pre_samples = 16'd2; post_samples = 16'd2; trigger_level = 16'd5000;
        d0 = n_done;
        pulse_start();
        sample(16'd10, 32'h4000_0000);
        sample(16'd20, 32'h4000_0004);
        sample(16'd30, 32'h4000_0008);
        check("abort_armed_before", u_armed, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_pulse", u_aborted, 1'b1);
        check("abort_busy_low", u_busy, 1'b0);
        check("abort_no_done", 64'(n_done - d0), 64'd0);
        tick();
        check("abort_pulse_single", u_aborted, 1'b0);
        in_data_valid = 1'b1;
        #1;
        check("abort_capture_off", u_capture_en, 1'b0);
        in_data_valid = 1'b0;
        check("abort_trig_retained", u_trig_address, 32'h3000_0004);
        tick();
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("abort_start_same_cycle", {u_busy, u_aborted}, 2'b00);

        // ---------------- auto_rearm, config change between captures ----------------
        pre_samples = 16'd1; post_samples = 16'd1; trigger_level = 16'd100; auto_rearm = 1'b1;
        c0 = n_cap; d0 = n_done;
        pulse_start();
        pre_samples = 16'd2; post_samples = 16'd2; trigger_level = 16'd200;
        sample(16'd50,  32'h5000_0000); tick();
        sample(16'd150, 32'h5000_0004);
        check("rearm1_trig_addr", u_trig_address, 32'h5000_0004);
        tick();
        sample(16'd160, 32'h5000_0008);
        check("rearm1_done", u_done, 1'b1);
        tick();
        check("rearm_restarted", {u_busy, u_done}, 2'b10);
        auto_rearm = 1'b0;
        sample(16'd50, 32'h5000_000C); tick();
        check("rearm2_pre2_not_armed", u_armed, 1'b0);
        sample(16'd60, 32'h5000_0010); tick();
        check("rearm2_armed", u_armed, 1'b1);
        sample(16'd150, 32'h5000_0014);
        check("rearm2_new_level", u_armed, 1'b1);
        tick();
        sample(16'd250, 32'h5000_0018);
        check("rearm2_trig_addr", u_trig_address, 32'h5000_0018);
        tick();
        sample(16'd10, 32'h5000_001C); tick();
        check("rearm2_post2", u_done, 1'b0);
        sample(16'd20, 32'h5000_0020);
        check("rearm2_done", u_done, 1'b1);
        tick();
        check("rearm_idle", u_busy, 1'b0);
        check("rearm_done_count", 64'(n_done - d0), 64'd2);
        check("rearm_capture_count", 64'(n_cap - c0), 64'd9);

        // ---------------- rst mid-POST ----------------
        pre_samples = 16'd0; post_samples = 16'd5; trigger_level = 16'd100;
        d0 = n_done; a0 = n_abort;
        pulse_start();
        tick();
        sample(16'd50,  32'h6000_0000);
        sample(16'd150, 32'h6000_0004);
        sample(16'd160, 32'h6000_0008);
        check("rst_post_busy", {u_busy, u_armed}, 2'b10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_post_idle", u_busy, 1'b0);
        check("rst_post_trig_cleared", u_trig_address, 32'h0);
        repeat (3) tick();
        check("rst_post_no_done", 64'(n_done - d0), 64'd0);
        check("rst_post_no_abort", 64'(n_abort - a0), 64'd0);

        // ---------------- trigger at the top DMA address ----------------
        post_samples = 16'd0;
        pulse_start();
        tick();
        sample(16'd50,  32'hFFFF_FFFE);
        sample(16'd150, 32'hFFFF_FFFF);
        check("top_addr_trig", u_trig_address, 32'hFFFF_FFFF);
        tick();
        check("top_addr_done", u_done, 1'b1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/acq_trigger_sequencer.md
Name: acq_trigger_sequencer

Overview:
- Oscilloscope-style acquisition controller that sits between the ADC sample stream and the DMA writer.
- Sequences each capture through four phases: pre-trigger fill, armed wait, post-trigger fill and completion.
- Detects level crossings on the validated sample stream and latches the DMA address of the trigger sample, so the HPS can locate it in the buffer.
- Gates DMA writes so that only the capture window is stored.

Parameters:
- DATA_WIDTH, 16, sample width.
- ADDR_WIDTH, 32, DMA address width.
- CNT_WIDTH, 16, width of the pre/post sample counters.
- TWOS_COMPLEMENT, 0, 1 = signed sample/level compare, 0 = unsigned.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  one-cycle arm request from HPS
- abort  in  1  one-cycle cancel request
- auto_rearm  in  1  1 = restart pre-fill after DONE
- pre_samples  in  CNT_WIDTH  valid samples captured before arming
- post_samples  in  CNT_WIDTH  valid samples captured after the trigger sample
- trigger_level  in  DATA_WIDTH  crossing threshold
- trig_edge  in  1  0 = rising, 1 = falling
- in_data_valid  in  1  sample strobe
- in_data  in  DATA_WIDTH  sample
- in_dma_master_address  in  ADDR_WIDTH  current DMA write address
- capture_en  out  1  DMA write enable for the current sample
- busy  out  1  state is not IDLE
- armed  out  1  state is ARMED
- done  out  1  one-cycle completion pulse
- aborted  out  1  one-cycle abort pulse
- trig_address  out  ADDR_WIDTH  DMA address of the trigger sample

Behaviour:
- Reset: rst is synchronous and active-high; clk is the clock.
  - Reset values: state = IDLE; done, aborted, armed and busy = 0; trig_address = 0; counters = 0; prev_valid = 0.
  - capture_en = 0, because it is a function of state.
  - An rst asserted mid-capture drops to IDLE on the next edge with no done and no aborted pulse.
- States: IDLE, PRE, ARMED, POST, DONE.
- IDLE:
  - On start, latch pre_samples, post_samples, trigger_level and trig_edge into shadow registers.
  - Then clear the counter and prev_valid, and go to PRE.
  - Configuration changes after start have no effect until the next start.
- PRE: count valid samples. When count reaches pre_samples, go to ARMED on that same edge. If pre_samples = 0, PRE lasts exactly one cycle.
- ARMED: trigger is evaluated only on a valid sample, and only when prev_valid = 1.
  - Rising: prev < level and cur >= level.
  - Falling: prev > level and cur <= level.
  - On a hit: trig_address <= in_dma_master_address of that cycle, clear the counter, go to POST.
- Previous-sample register: updates on every valid sample in PRE, ARMED and POST. prev_valid sets on the first valid sample after start. A crossing that straddles the PRE-to-ARMED boundary therefore fires.
- POST: count valid samples; when count reaches post_samples, go to DONE. The trigger sample itself is not counted. post_samples = 0 leaves POST after one cycle.
- DONE: done = 1 for exactly one cycle, then IDLE. With auto_rearm = 1, DONE re-latches the shadows and goes to PRE instead.
- capture_en = in_data_valid and state in {PRE, ARMED, POST}. It is combinational (zero latency) and includes the trigger sample.
- Total stored samples = pre_samples + (samples while ARMED) + 1 + post_samples.
- Abort:
  - In any non-IDLE state: next state IDLE, aborted pulses one cycle, trig_address retained.
  - Abort together with start in IDLE: abort wins, state stays IDLE, no pulse.
  - Abort in DONE: the done pulse still occurs, no rearm.
- start outside IDLE is ignored.
- Compare: a signed or unsigned full-width compare selected by TWOS_COMPLEMENT.
- Counters:
  - Saturate at their maximum and never wrap.
  - pre_samples = max makes PRE terminate at the max count.
- DMA address wrap: 32'hFFFFFFFF to 0 is reported verbatim and needs no special handling.

Decomposition:
- Package acq_pkg holds:
  - the state enum typedef (IDLE, PRE, ARMED, POST, DONE);
  - the edge constants EDGE_RISING = 0 and EDGE_FALLING = 1.
- One sub-module, level_cross_detect, contains:
  - the prev-sample register and prev_valid;
  - the signed/unsigned compare and edge select;
  - a one-bit hit output, qualified by in_data_valid.

Test Plan:
- Single rising capture:
  - Stimulus: level = 1000, pre = 4, post = 3, ramp 0..2045 with one valid sample every 6 clocks.
  - Expected: trigger on the sample equal to 1000; trig_address matches that cycle's address; capture_en count = 4 + armed samples + 1 + 3; one done pulse.
- Falling edge, signed:
  - Stimulus: TWOS_COMPLEMENT = 1, level = -5, samples 10, 0, -4, -6.
  - Expected: trigger on -6; no trigger on an unsigned-misread pattern.
- Zero-length windows:
  - Stimulus: pre = 0, post = 0.
  - Expected: PRE and POST each last one cycle; done follows the trigger sample by 2 cycles.
- Abort in ARMED with no crossing:
  - Expected: aborted pulse, no done, busy = 0 next cycle, capture_en = 0 afterwards.
- auto_rearm = 1:
  - Stimulus: two consecutive captures.
  - Expected: done pulses twice; shadow configuration changed between the captures takes effect only for the second.
- Boundary events:
  - rst mid-POST: IDLE, no pulses.
  - start while busy: ignored.
  - Trigger address at 32'hFFFFFFFF: reported unchanged.
